// File: rtl/led_pwm_ctrl.sv
// led_pwm_ctrl: Avalon-MM register block driving 8 LEDs with independent
// 8-bit PWM brightness and an optional global blink gate.
// Optional feature macro: LED_PWM_BLINK_EN (blink counter, blink_phase and
// BLINK_PERIOD register are built only when it is defined).
module led_pwm_ctrl #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [2:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic [7:0]  LED
);

    localparam logic [15:0] LP_TICK_MAX = 16'(PRESCALE - 1);

    // Programmable state
    logic        r_enable;
    logic [7:0]  r_mask;
    logic [31:0] r_duty_lo;
    logic [31:0] r_duty_hi;

    // Counters
    logic [15:0] r_tick_cnt;
    logic [7:0]  r_pwm_cnt;

    // Outputs
    logic [31:0] r_readdata;
    logic [7:0]  r_led;

    // Combinational helpers
    logic        w_tick;
    logic        w_frame;
    logic [63:0] w_duty_all;
    logic [7:0]  w_lit;
    logic [7:0]  w_led_next;
    logic [31:0] w_rdata;
    logic        w_blink_en;
    logic        w_blink_phase;
    logic [23:0] w_blink_period;
    logic        w_blink_gate;

    assign w_tick     = (r_tick_cnt == LP_TICK_MAX);
    assign w_frame    = w_tick & (r_pwm_cnt == 8'hFF);
    assign w_duty_all = {r_duty_hi, r_duty_lo};

    // Tick divider: counts 0..PRESCALE-1 and wraps on tick
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_tick_cnt <= 16'd0;
        end else if (w_tick) begin
            r_tick_cnt <= 16'd0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 16'd1;
        end
    end

    // PWM position counter: advances once per tick, 255 wraps to 0
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pwm_cnt <= 8'd0;
        end else if (w_tick) begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
        end else begin
            r_pwm_cnt <= r_pwm_cnt;
        end
    end

    // Host-writable enable, mask and duty registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_enable  <= 1'b0;
            r_mask    <= 8'h00;
            r_duty_lo <= 32'd0;
            r_duty_hi <= 32'd0;
        end else if (avs_write) begin
            case (avs_address)
                3'd0:    r_enable  <= avs_writedata[0];
                3'd1:    r_mask    <= avs_writedata[7:0];
                3'd2:    r_duty_lo <= avs_writedata;
                3'd3:    r_duty_hi <= avs_writedata;
                default: r_enable  <= r_enable;
            endcase
        end else begin
            r_enable <= r_enable;
        end
    end

`ifdef LED_PWM_BLINK_EN
    logic        r_blink_en;
    logic [23:0] r_blink_period;
    logic [23:0] r_blink_cnt;
    logic        r_blink_phase;
    logic        w_period_wr;

    assign w_period_wr = avs_write & (avs_address == 3'd4);

    // Blink enable bit (CTRL[1]) and blink half-period register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_blink_en     <= 1'b0;
            r_blink_period <= 24'd0;
        end else if (avs_write && (avs_address == 3'd0)) begin
            r_blink_en <= avs_writedata[1];
        end else if (w_period_wr) begin
            r_blink_period <= avs_writedata[23:0];
        end else begin
            r_blink_en <= r_blink_en;
        end
    end

    // Blink frame counter; toggles phase every BLINK_PERIOD frames.
    // A period write restarts the half-period in the lit phase; the >=
    // compare keeps a shrunk period from running the counter past its end.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_blink_cnt   <= 24'd0;
            r_blink_phase <= 1'b0;
        end else if (w_period_wr) begin
            r_blink_cnt   <= 24'd0;
            r_blink_phase <= 1'b1;
        end else if (r_blink_period == 24'd0) begin
            r_blink_cnt   <= 24'd0;
            r_blink_phase <= 1'b1;
        end else if (w_frame) begin
            if (r_blink_cnt >= (r_blink_period - 24'd1)) begin
                r_blink_cnt   <= 24'd0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 24'd1;
            end
        end else begin
            r_blink_cnt <= r_blink_cnt;
        end
    end

    assign w_blink_en     = r_blink_en;
    assign w_blink_phase  = r_blink_phase;
    assign w_blink_period = r_blink_period;
`else
    assign w_blink_en     = 1'b0;
    assign w_blink_phase  = 1'b1;
    assign w_blink_period = 24'd0;
`endif

    assign w_blink_gate = ~w_blink_en | w_blink_phase;

    // Per-LED PWM compare: 0xFF is fully lit, otherwise lit while pwm_cnt < duty
    always_comb begin
        w_lit = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (w_duty_all[8*i +: 8] == 8'hFF) begin
                w_lit[i] = 1'b1;
            end else if (r_pwm_cnt < w_duty_all[8*i +: 8]) begin
                w_lit[i] = 1'b1;
            end else begin
                w_lit[i] = 1'b0;
            end
        end
    end

    assign w_led_next = (r_enable & w_blink_gate) ? (w_lit & r_mask) : 8'h00;

    // LED output register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_led <= 8'h00;
        end else begin
            r_led <= w_led_next;
        end
    end

    // Read data selection from current (pre-write) register state
    always_comb begin
        w_rdata = 32'd0;
        case (avs_address)
            3'd0:    w_rdata = {30'd0, w_blink_en, r_enable};
            3'd1:    w_rdata = {24'd0, r_mask};
            3'd2:    w_rdata = r_duty_lo;
            3'd3:    w_rdata = r_duty_hi;
            3'd4:    w_rdata = {8'd0, w_blink_period};
            3'd5:    w_rdata = {23'd0, w_blink_phase, r_pwm_cnt};
            default: w_rdata = 32'd0;
        endcase
    end

    // Read data register: latency 1, holds until the next read
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_readdata <= 32'd0;
        end else if (avs_read) begin
            r_readdata <= w_rdata;
        end else begin
            r_readdata <= r_readdata;
        end
    end

    assign avs_readdata = r_readdata;
    assign LED          = r_led;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed testbench for led_pwm_ctrl (PRESCALE = 1).
// Blink-specific vectors are included when LED_PWM_BLINK_EN is defined.
module tb_led_pwm_ctrl;

    logic        CLK;
    logic        RESET_N;
    logic [2:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic [7:0]  LED;

    int n_checks;
    int n_errors;
    int n_edges;
    int hi_cnt [8];

    led_pwm_ctrl #(.PRESCALE(1)) u_dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .LED           (LED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Clock edges seen since reset release; with PRESCALE=1 pwm_cnt = n_edges mod 256
    always @(posedge CLK) begin
        if (!RESET_N) n_edges <= 0;
        else          n_edges <= n_edges + 1;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        @(negedge CLK);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        @(negedge CLK);
        avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
        @(negedge CLK);
        avs_address = addr;
        avs_read    = 1'b1;
        @(negedge CLK);
        avs_read    = 1'b0;
        data        = avs_readdata;
    endtask

    // STATUS expected at the sampling negedge after a read (period 0 => phase 1)
    function automatic logic [31:0] status_exp();
        return {23'd0, 1'b1, 8'(n_edges - 1)};
    endfunction

    task automatic measure(input int n);
        for (int b = 0; b < 8; b++) hi_cnt[b] = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            for (int b = 0; b < 8; b++) if (LED[b]) hi_cnt[b]++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got hang expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] exp_rd;
        n_checks      = 0;
        n_errors      = 0;
        RESET_N       = 1'b0;
        avs_address   = 3'd0;
        avs_write     = 1'b0;
        avs_writedata = 32'd0;
        avs_read      = 1'b0;

        repeat (3) @(negedge CLK);
        check_value("reset_led", {24'd0, LED}, 32'h0);
        check_value("reset_readdata", avs_readdata, 32'h0);
        RESET_N = 1'b1;

        // Reset values of every address
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            exp_rd = (a == 5) ? status_exp() : 32'h0;
            check_value($sformatf("reset_reg%0d", a), rd, exp_rd);
        end
        check_value("led_after_reset", {24'd0, LED}, 32'h0);

        // Register readback and unused-bit masking
        bus_write(3'd0, 32'hFFFF_FFFF);
        bus_read(3'd0, rd);
`ifdef LED_PWM_BLINK_EN
        check_value("ctrl_readback", rd, 32'h3);
`else
        check_value("ctrl_readback", rd, 32'h1);
`endif
        bus_write(3'd0, 32'h0);
        bus_write(3'd4, 32'h00AB_CDEF);
        bus_read(3'd4, rd);
`ifdef LED_PWM_BLINK_EN
        check_value("period_readback", rd, 32'h00AB_CDEF);
`else
        check_value("period_readback", rd, 32'h0);
`endif
        bus_write(3'd4, 32'h0);
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_read(3'd6, rd);
        check_value("reg6_readback", rd, 32'h0);
        bus_write(3'd1, 32'hFFFF_FF3C);
        bus_read(3'd1, rd);
        check_value("mask_readback", rd, 32'h3C);

        // Same-cycle read and write returns the old value
        @(negedge CLK);
        avs_address   = 3'd1;
        avs_writedata = 32'h0000_00A5;
        avs_write     = 1'b1;
        avs_read      = 1'b1;
        @(negedge CLK);
        avs_write     = 1'b0;
        avs_read      = 1'b0;
        check_value("rw_same_cycle_old", avs_readdata, 32'h3C);
        bus_read(3'd1, rd);
        check_value("rw_followup_new", rd, 32'hA5);

        // Duty 0x40 on LED0 only
        bus_write(3'd0, 32'h1);
        bus_write(3'd1, 32'h01);
        bus_write(3'd2, 32'h0000_0040);
        measure(256);
        check_value("duty40_led0_hi", hi_cnt[0], 32'd64);
        check_value("duty40_others_hi",
                    hi_cnt[1] + hi_cnt[2] + hi_cnt[3] + hi_cnt[4] + hi_cnt[5] + hi_cnt[6] + hi_cnt[7],
                    32'd0);

        // Duty 0xFF on LED2, all others duty 0, all unmasked
        bus_write(3'd2, 32'h00FF_0000);
        bus_write(3'd3, 32'h0);
        bus_write(3'd1, 32'hFF);
        bus_write(3'd0, 32'h1);
        measure(256);
        check_value("dutyFF_led2_hi", hi_cnt[2], 32'd256);
        check_value("duty0_others_hi",
                    hi_cnt[0] + hi_cnt[1] + hi_cnt[3] + hi_cnt[4] + hi_cnt[5] + hi_cnt[6] + hi_cnt[7],
                    32'd0);

        // Boundary duties: 1 on LED4, 254 on LED7
        bus_write(3'd3, 32'hFE00_0001);
        measure(256);
        check_value("duty01_led4_hi", hi_cnt[4], 32'd1);
        check_value("dutyFE_led7_hi", hi_cnt[7], 32'd254);
        check_value("dutyFF_led2_still", hi_cnt[2], 32'd256);
        check_value("duty0_rest_hi", hi_cnt[0] + hi_cnt[1] + hi_cnt[3] + hi_cnt[5] + hi_cnt[6], 32'd0);

        // Clearing enable: LED drops exactly two cycles after the write cycle
        bus_write(3'd0, 32'h0);
        check_value("disable_led_one_cycle", {31'd0, LED[2]}, 32'h1);
        @(negedge CLK);
        check_value("disable_led_two_cycles", {24'd0, LED}, 32'h0);
        bus_read(3'd5, rd);
        check_value("status_running_1", rd, status_exp());
        repeat (37) @(negedge CLK);
        bus_read(3'd5, rd);
        check_value("status_running_2", rd, status_exp());
        measure(256);
        check_value("disabled_led2_dark", hi_cnt[2], 32'd0);

        // Re-enable latency
        bus_write(3'd0, 32'h1);
        check_value("enable_led_one_cycle", {31'd0, LED[2]}, 32'h0);
        @(negedge CLK);
        check_value("enable_led_two_cycles", {31'd0, LED[2]}, 32'h1);

`ifdef LED_PWM_BLINK_EN
        begin
            int run;
            bit found;
            bus_write(3'd3, 32'h0);
            bus_write(3'd1, 32'h01);
            bus_write(3'd2, 32'h0000_00FF);
            bus_write(3'd0, 32'h3);
            bus_write(3'd4, 32'h2);
            check_value("blink_starts_on", {31'd0, LED[0]}, 32'h1);
            found = 1'b0;
            for (int k = 0; k < 2000 && !found; k++) begin
                @(negedge CLK);
                if (!LED[0]) found = 1'b1;
            end
            check_value("blink_first_fall", {31'd0, found}, 32'h1);
            run = 1;
            while (run < 2000) begin
                @(negedge CLK);
                if (LED[0]) break;
                run++;
            end
            check_value("blink_off_run", run, 32'd512);
            run = 1;
            while (run < 2000) begin
                @(negedge CLK);
                if (!LED[0]) break;
                run++;
            end
            check_value("blink_on_run", run, 32'd512);
            bus_read(3'd5, rd);
            check_value("blink_status_phase", {31'd0, rd[8]}, 32'h0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
